// File: rtl/bsg_link_ddr_downstream_ch.sv
// Downstream channel of a DDR link: assembles io beats into core words, buffers
// them in a credit-sized FIFO and returns one toggle token per TOKEN_DECIM pops.
module bsg_link_ddr_downstream_ch #(
    parameter int IO_W        = 16,
    parameter int BEATS       = 2,
    parameter int FIFO_DEPTH  = 8,
    parameter int TOKEN_DECIM = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  io_valid_i,
    input  logic [IO_W-1:0]       io_data_i,
    output logic                  core_valid_o,
    output logic [IO_W*BEATS-1:0] core_data_o,
    input  logic                  core_yumi_i,
    output logic                  token_o,
    output logic                  overflow_o
);

    localparam int CW     = IO_W * BEATS;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int DEC_W  = (TOKEN_DECIM > 1) ? $clog2(TOKEN_DECIM) : 1;

    logic [BEAT_W-1:0] beat_cnt;
    logic [IO_W-1:0]   slot_r [BEATS];
    logic [CW-1:0]     word_in;
    logic              last_beat;

    logic [CW-1:0]     mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic [DEC_W-1:0]  dec_cnt;

    logic push, pop, full, do_write, dec_wrap;

    assign last_beat = (beat_cnt == BEAT_W'(BEATS - 1));
    assign push      = !rst && io_valid_i && last_beat;
    assign pop       = !rst && core_yumi_i && (count != '0);
    assign full      = (count == CNT_W'(FIFO_DEPTH));
    // A full FIFO still accepts a word when the head leaves in the same cycle.
    assign do_write  = push && (!full || pop);
    assign dec_wrap  = (dec_cnt == DEC_W'(TOKEN_DECIM - 1));

    // Completed word: the arriving beat on top, earlier beats from the slots.
    always_comb begin
        word_in = '0;
        for (int i = 0; i < BEATS - 1; i++) begin
            word_in[i*IO_W +: IO_W] = slot_r[i];
        end
        word_in[(BEATS-1)*IO_W +: IO_W] = io_data_i;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            beat_cnt <= '0;
        end else if (io_valid_i) begin
            beat_cnt <= last_beat ? '0 : beat_cnt + BEAT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && io_valid_i) begin
            slot_r[beat_cnt] <= io_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (do_write) begin
            mem[wr_ptr] <= word_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            overflow_o <= 1'b0;
        end else begin
            if (do_write) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (do_write && !pop) begin
                count <= count + CNT_W'(1);
            end else if (pop && !do_write) begin
                count <= count - CNT_W'(1);
            end
            if (push && !do_write) begin
                overflow_o <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dec_cnt <= '0;
            token_o <= 1'b0;
        end else if (pop) begin
            dec_cnt <= dec_wrap ? '0 : dec_cnt + DEC_W'(1);
            if (dec_wrap) begin
                token_o <= ~token_o;
            end
        end
    end

    assign core_valid_o = (count != '0);
    assign core_data_o  = mem[rd_ptr];

endmodule

// File: tb/tb_bsg_link_ddr_downstream_ch.sv
// Bench for bsg_link_ddr_downstream_ch: directed vector table, hand-written
// corner sequences, and random traffic against a queue-based reference model.
module tb_bsg_link_ddr_downstream_ch;

    localparam int IO_W  = 16;
    localparam int CW    = 32;
    localparam int DEPTH = 8;
    localparam int DECIM = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          io_valid_i = 1'b0;
    logic [15:0]   io_data_i = '0;
    logic          core_valid_o;
    logic [31:0]   core_data_o;
    logic          core_yumi_i = 1'b0;
    logic          token_o;
    logic          overflow_o;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    bsg_link_ddr_downstream_ch #(
        .IO_W(IO_W), .BEATS(2), .FIFO_DEPTH(DEPTH), .TOKEN_DECIM(DECIM)
    ) dut (
        .clk(clk), .rst(rst),
        .io_valid_i(io_valid_i), .io_data_i(io_data_i),
        .core_valid_o(core_valid_o), .core_data_o(core_data_o),
        .core_yumi_i(core_yumi_i),
        .token_o(token_o), .overflow_o(overflow_o)
    );

    // Reference model: a queue of whole words plus a pending half word.
    logic [31:0] m_q[$];
    logic [15:0] m_part;
    bit          m_have_part;
    bit          m_ovf;
    int          m_pops;
    bit          m_tok;

    task automatic model_step(input bit r, input bit v, input logic [15:0] d, input bit y);
        bit          done;
        logic [31:0] w;
        done = 0;
        w    = '0;
        if (r) begin
            m_q.delete();
            m_have_part = 0;
            m_ovf       = 0;
            m_pops      = 0;
            m_tok       = 0;
        end else begin
            if (v) begin
                if (!m_have_part) begin
                    m_part      = d;
                    m_have_part = 1;
                end else begin
                    w           = {d, m_part};
                    m_have_part = 0;
                    done        = 1;
                end
            end
            if (y && m_q.size() > 0) begin
                void'(m_q.pop_front());
                m_pops++;
                if (m_pops % DECIM == 0) m_tok = ~m_tok;
            end
            if (done) begin
                if (m_q.size() < DEPTH) m_q.push_back(w);
                else m_ovf = 1;
            end
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

    task automatic check_model();
        check("model_valid", 32'(core_valid_o), 32'(m_q.size() > 0));
        if (m_q.size() > 0) check("model_data", core_data_o, m_q[0]);
        check("model_token", 32'(token_o), 32'(m_tok));
        check("model_overflow", 32'(overflow_o), 32'(m_ovf));
    endtask

    // One clock: drive inputs, take the edge, update the model, sample 1ns later.
    task automatic cyc(input bit r, input bit v, input logic [15:0] d, input bit y);
        rst         = r;
        io_valid_i  = v;
        io_data_i   = d;
        core_yumi_i = y;
        @(posedge clk);
        model_step(r, v, d, y);
        #1;
    endtask

    task automatic push_word(input logic [15:0] lo, input logic [15:0] hi);
        cyc(0, 1, lo, 0);
        cyc(0, 1, hi, 0);
    endtask

    typedef struct {
        bit          r;
        bit          v;
        logic [15:0] d;
        bit          y;
        bit          e_valid;
        logic [31:0] e_data;
        bit          e_tok;
        bit          e_ovf;
    } vec_t;

    vec_t vecs[$];

    initial begin
        // Reset, two-beat word, non-contiguous beats, reset discarding a partial word.
        vecs.push_back('{1, 0, 16'h0000, 0, 0, 32'h0, 0, 0});
        vecs.push_back('{0, 1, 16'h1111, 0, 0, 32'h0, 0, 0});
        vecs.push_back('{0, 1, 16'h2222, 0, 1, 32'h22221111, 0, 0});
        vecs.push_back('{0, 0, 16'h0000, 1, 0, 32'h0, 0, 0});
        vecs.push_back('{0, 1, 16'hAAAA, 1, 0, 32'h0, 0, 0});
        vecs.push_back('{0, 0, 16'h0000, 0, 0, 32'h0, 0, 0});
        vecs.push_back('{0, 0, 16'h0000, 0, 0, 32'h0, 0, 0});
        vecs.push_back('{0, 0, 16'h0000, 0, 0, 32'h0, 0, 0});
        vecs.push_back('{0, 1, 16'hBBBB, 0, 1, 32'hBBBBAAAA, 0, 0});
        vecs.push_back('{0, 0, 16'h0000, 1, 0, 32'h0, 1, 0});
        vecs.push_back('{0, 0, 16'h0000, 0, 0, 32'h0, 1, 0});
        vecs.push_back('{0, 1, 16'h1234, 0, 0, 32'h0, 1, 0});
        vecs.push_back('{1, 1, 16'h9999, 1, 0, 32'h0, 0, 0});
        vecs.push_back('{0, 1, 16'h5555, 0, 0, 32'h0, 0, 0});
        vecs.push_back('{0, 1, 16'h6666, 0, 1, 32'h66665555, 0, 0});
        vecs.push_back('{0, 0, 16'h0000, 1, 0, 32'h0, 0, 0});

        foreach (vecs[i]) begin
            cyc(vecs[i].r, vecs[i].v, vecs[i].d, vecs[i].y);
            check($sformatf("vec%0d_valid", i), 32'(core_valid_o), 32'(vecs[i].e_valid));
            if (vecs[i].e_valid) check($sformatf("vec%0d_data", i), core_data_o, vecs[i].e_data);
            check($sformatf("vec%0d_token", i), 32'(token_o), 32'(vecs[i].e_tok));
            check($sformatf("vec%0d_overflow", i), 32'(overflow_o), 32'(vecs[i].e_ovf));
        end

        // Nine words into an eight-entry buffer: ninth dropped, overflow sticky.
        cyc(1, 0, 0, 0);
        for (int k = 1; k <= 9; k++) push_word(16'h0100 + 16'(k), 16'hA000 + 16'(k));
        check("ovf_flag", 32'(overflow_o), 32'd1);
        for (int k = 1; k <= 8; k++) begin
            check($sformatf("ovf_pop%0d_valid", k), 32'(core_valid_o), 32'd1);
            check($sformatf("ovf_pop%0d_data", k), core_data_o, {16'hA000 + 16'(k), 16'h0100 + 16'(k)});
            cyc(0, 0, 0, 1);
            check("ovf_sticky", 32'(overflow_o), 32'd1);
        end
        check("ovf_empty", 32'(core_valid_o), 32'd0);

        // Full buffer, completing beat together with a pop: no drop, new word last.
        cyc(1, 0, 0, 0);
        for (int k = 1; k <= 8; k++) push_word(16'h0200 + 16'(k), 16'hB000 + 16'(k));
        cyc(0, 1, 16'h0209, 0);
        cyc(0, 1, 16'hB009, 1);
        check("full_pp_ovf", 32'(overflow_o), 32'd0);
        for (int k = 2; k <= 9; k++) begin
            check($sformatf("full_pp_pop%0d", k), core_data_o, {16'hB000 + 16'(k), 16'h0200 + 16'(k)});
            check_model();
            cyc(0, 0, 0, 1);
        end
        check("full_pp_empty", 32'(core_valid_o), 32'd0);
        check("full_pp_ovf_end", 32'(overflow_o), 32'd0);

        // Token return: one toggle after every second pop.
        cyc(1, 0, 0, 0);
        for (int k = 0; k < 4; k++) push_word(16'(k), 16'(k + 16));
        check("tok_idle", 32'(token_o), 32'd0);
        begin
            bit tok_exp [5];
            tok_exp = '{0, 1, 1, 0, 0};
            for (int k = 0; k < 5; k++) begin
                cyc(0, 0, 0, (k < 4));
                check($sformatf("tok_after_pop%0d", k + 1), 32'(token_o), 32'(tok_exp[k]));
            end
        end

        // Random traffic against the model, with the pop rate shifting per block.
        cyc(1, 0, 0, 0);
        check_model();
        for (int blk = 0; blk < 12; blk++) begin
            int yp;
            yp = (blk % 3 == 0) ? 10 : ((blk % 3 == 1) ? 50 : 90);
            for (int c = 0; c < 200; c++) begin
                bit r;
                r = ($urandom_range(0, 299) == 0);
                cyc(r, $urandom_range(0, 99) < 70, 16'($urandom), $urandom_range(0, 99) < yp);
                check_model();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
